alu16b_issue: RTL and testbench
===============================

Name: alu16b_issue

Overview:
- Issue/writeback stage wrapped around the 16-bit combinational ALU (A/B operands, 3-bit opcode, 16-bit result, carry-out).
- Accepts register-to-register instructions over a valid/ready handshake and reads operands from a small internal register file.
- Drives the ALU from an execute (E) register and writes the ALU result back one cycle later.
- Maintains carry/zero flags and a retired-operation counter.

Parameters:
- DW, 16, datapath width; must match the ALU width.
- AW, 2, register address width; the register file holds 2**AW entries.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  instruction accepted when high together with instr_valid.
- instr_op  in  3  ALU opcode: 000 NOT A, 001 AND, 010 XOR, 011 OR, 100 A-1, 101 ADD, 110 SUB, 111 A+1.
- instr_rd  in  AW  destination register.
- instr_rs1  in  AW  source register for A.
- instr_rs2  in  AW  source register for B.
- ld_en  in  1  direct register load request.
- ld_ready  out  1  load accepted when high together with ld_en.
- ld_addr  in  AW  load address.
- ld_data  in  DW  load data.
- alu_a  out  DW  to ALU in_a.
- alu_b  out  DW  to ALU in_b.
- alu_op  out  3  to ALU opcode.
- alu_result  in  DW  from ALU result.
- alu_cout  in  1  from ALU cout.
- wb_valid  out  1  one-cycle pulse at writeback.
- wb_addr  out  AW  register written.
- wb_data  out  DW  value written.
- flag_c  out  1  carry flag.
- flag_z  out  1  zero flag.
- op_count  out  16  retired instruction count.
- rf_raddr  in  AW  debug read address.
- rf_rdata  out  DW  combinational read of the register file at rf_raddr.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While rst_n is low, the following are all 0: every register-file entry, the E stage (e_valid, e_op, e_rd, e_a, e_b), wb_valid, wb_addr, wb_data, flag_c, flag_z, op_count.
- Reset asserted mid-instruction discards the E stage; no writeback occurs.
- Handshake: ld_ready = ~e_valid. instr_ready = ~ld_en. Loads have priority, so when instr_valid, ld_en and ld_ready are all high, only the load is taken.
- While e_valid is high, ld_en is stalled by ld_ready=0; instructions may still be accepted.
- Load: ld_en & ld_ready writes ld_data into rf[ld_addr] at the edge. There is no wb_valid pulse and flags are untouched.
- Accept at edge N: e_valid<=1; e_op, e_rd latched. e_a and e_b take the operand values after forwarding.
- Forwarding: if e_valid is high and e_rd == rs1 at edge N, e_a takes alu_result instead of rf[rs1]. The same rule applies to rs2/e_b.
- ALU drive: alu_a=e_a, alu_b=e_b, alu_op=e_op, all straight from registers. These outputs hold their last values when e_valid=0.
- Writeback at edge N+1, when e_valid=1:
  - rf[e_rd] <= alu_result.
  - wb_valid <= 1; wb_addr <= e_rd; wb_data <= alu_result.
  - op_count increments, wrapping from 0xFFFF to 0.
  - e_valid <= 1 if a new instruction is accepted at the same edge, else 0.
- Latency: result is visible in rf and wb_data one clock after acceptance. Sustained throughput is 1 instruction per clock, back-to-back, with no stalls for data hazards.
- Flags, at writeback:
  - flag_z <= (alu_result == 0) for every opcode.
  - flag_c <= alu_cout only for opcodes 101 and 110; for all other opcodes flag_c holds.
- rf_rdata: combinational read; it shows the pre-edge value during the writeback cycle.
- Write conflict: a load and a writeback cannot coincide, because ld_ready=0 whenever e_valid=1.
- rd == rs1 == rs2 is legal. Forwarding applies to both operands.

Test Plan:
- Reset/load: release rst_n, load r0=0x1234, r1=0x00FF -> rf_rdata(r0)=0x1234, flags 0, op_count 0, wb_valid never pulses.
- ADD carry: r0=0xFFFF, r1=0x0001, ADD r2=r0+r1 -> one cycle later wb_valid=1, wb_addr=2, wb_data=0x0000, flag_c=1, flag_z=1, op_count=1.
- Flag hold: after the ADD scenario, AND r3=r0&r1 with r0=0xF0F0, r1=0x0FF0 -> wb_data=0x00F0, flag_z=0, flag_c stays 1.
- Forwarding: r0=5, back-to-back A+1 r0=r0 (opcode 111) three times -> wb_data 6, 7, 8 on consecutive cycles; final rf[0]=8.
- Priority: instr_valid and ld_en high together with E empty -> instr_ready=0, load committed, instruction accepted the next cycle. A load requested while e_valid=1 waits on ld_ready=0.
- Async reset mid-op: assert rst_n low between accept and writeback -> no write to rd, all outputs 0 immediately without a clock edge; op_count wraps 0xFFFF->0 in a separate preload run.

Source files
------------

// File: rtl/alu16b_issue.sv
// Issue/writeback stage around an external combinational ALU: register file,
// single execute register with result forwarding, flags and retire counter.
module alu16b_issue #(
  parameter int DW = 16,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs1,
  input  logic [AW-1:0] instr_rs2,
  input  logic          ld_en,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_cout,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          flag_c,
  output logic          flag_z,
  output logic [15:0]   op_count,
  input  logic [AW-1:0] rf_raddr,
  output logic [DW-1:0] rf_rdata
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0] rf [NREG];
  logic          e_valid;
  logic [2:0]    e_op;
  logic [AW-1:0] e_rd;
  logic [DW-1:0] e_a;
  logic [DW-1:0] e_b;

  logic          ld_take;
  logic          instr_take;
  logic [DW-1:0] opnd_a;
  logic [DW-1:0] opnd_b;
  logic          carry_op;

  // Handshake decode; a pending load always blocks instruction issue.
  always_comb begin
    ld_ready    = ~e_valid;
    instr_ready = ~ld_en;
    ld_take     = ld_en & ~e_valid;
    instr_take  = instr_valid & ~ld_en;
  end

  // Operand select: the instruction in E writes back at this same edge, so bypass its result.
  always_comb begin
    if (e_valid && (e_rd == instr_rs1)) begin
      opnd_a = alu_result;
    end else begin
      opnd_a = rf[instr_rs1];
    end
    if (e_valid && (e_rd == instr_rs2)) begin
      opnd_b = alu_result;
    end else begin
      opnd_b = rf[instr_rs2];
    end
  end

  // Only ADD and SUB produce a meaningful carry.
  always_comb begin
    case (e_op)
      3'b101:  carry_op = 1'b1;
      3'b110:  carry_op = 1'b1;
      default: carry_op = 1'b0;
    endcase
  end

  // Execute register; fields hold when nothing is issued so the ALU inputs stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid <= 1'b0;
      e_op    <= 3'b000;
      e_rd    <= {AW{1'b0}};
      e_a     <= {DW{1'b0}};
      e_b     <= {DW{1'b0}};
    end else begin
      e_valid <= instr_take;
      if (instr_take) begin
        e_op <= instr_op;
        e_rd <= instr_rd;
        e_a  <= opnd_a;
        e_b  <= opnd_b;
      end
    end
  end

  // Register file write port; load and writeback are mutually exclusive through ld_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= {DW{1'b0}};
      end
    end else if (e_valid) begin
      rf[e_rd] <= alu_result;
    end else if (ld_take) begin
      rf[ld_addr] <= ld_data;
    end
  end

  // Writeback reporting, flags and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= {AW{1'b0}};
      wb_data  <= {DW{1'b0}};
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      op_count <= 16'd0;
    end else if (e_valid) begin
      wb_valid <= 1'b1;
      wb_addr  <= e_rd;
      wb_data  <= alu_result;
      flag_z   <= (alu_result == {DW{1'b0}});
      if (carry_op) begin
        flag_c <= alu_cout;
      end
      op_count <= op_count + 16'd1;
    end else begin
      wb_valid <= 1'b0;
    end
  end

  assign alu_a    = e_a;
  assign alu_b    = e_b;
  assign alu_op   = e_op;
  assign rf_rdata = rf[rf_raddr];

endmodule

// File: tb/tb_alu16b_issue.sv
// Scoreboard bench for alu16b_issue with a behavioural ALU closing the loop.
module tb_alu16b_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_op;
  logic [1:0]  instr_rd, instr_rs1, instr_rs2;
  logic        ld_en;
  logic        ld_ready;
  logic [1:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_cout;
  logic        wb_valid;
  logic [1:0]  wb_addr;
  logic [15:0] wb_data;
  logic        flag_c, flag_z;
  logic [15:0] op_count;
  logic [1:0]  rf_raddr;
  logic [15:0] rf_rdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_wb_cyc = -10;

  typedef struct {
    logic [1:0]  addr;
    logic [15:0] data;
    logic        c;
    logic        z;
    logic [15:0] cnt;
    bit          b2b;
  } exp_t;
  exp_t sbq[$];

  alu16b_issue #(.DW(16), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .ld_en(ld_en), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_c(flag_c), .flag_z(flag_z), .op_count(op_count),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Behavioural ALU; SUB carry is the carry out of A + ~B + 1.
  always_comb begin
    logic [16:0] t;
    t = 17'd0;
    alu_cout = 1'b0;
    alu_result = 16'd0;
    case (alu_op)
      3'b000: alu_result = ~alu_a;
      3'b001: alu_result = alu_a & alu_b;
      3'b010: alu_result = alu_a ^ alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a - 16'd1;
      3'b101: begin t = {1'b0, alu_a} + {1'b0, alu_b}; alu_result = t[15:0]; alu_cout = t[16]; end
      3'b110: begin t = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1; alu_result = t[15:0]; alu_cout = t[16]; end
      default: alu_result = alu_a + 16'd1;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every writeback pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_wb: got addr %0h data %0h expected no writeback", wb_addr, wb_data);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("wb_addr", {30'd0, wb_addr}, {30'd0, e.addr});
        chk("wb_data", {16'd0, wb_data}, {16'd0, e.data});
        chk("flag_c", {31'd0, flag_c}, {31'd0, e.c});
        chk("flag_z", {31'd0, flag_z}, {31'd0, e.z});
        chk("op_count", {16'd0, op_count}, {16'd0, e.cnt});
        if (e.b2b) chk("wb_back_to_back", cyc - last_wb_cyc, 32'd1);
      end
      last_wb_cyc = cyc;
    end
  end

  task automatic expect_wb(input logic [1:0] a, input logic [15:0] d, input logic c,
                           input logic z, input logic [15:0] n, input bit b2b);
    exp_t e;
    e.addr = a; e.data = d; e.c = c; e.z = z; e.cnt = n; e.b2b = b2b;
    sbq.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [15:0] d);
    bit done;
    done = 1'b0;
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (ld_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    ld_en = 1'b0;
    if (!done) chk("load_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [15:0] exp);
    rf_raddr = a;
    #1;
    chk(name, {16'd0, rf_rdata}, {16'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = 3'd0; instr_rd = 2'd0;
    instr_rs1 = 2'd0; instr_rs2 = 2'd0; ld_en = 1'b0; ld_addr = 2'd0;
    ld_data = 16'd0; rf_raddr = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    rd_chk("rst_rf0", 2'd0, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset/load
    load(2'd0, 16'h1234);
    load(2'd1, 16'h00FF);
    rd_chk("load_rf0", 2'd0, 16'h1234);
    rd_chk("load_rf1", 2'd1, 16'h00FF);
    chk("load_flags", {30'd0, flag_c, flag_z}, 32'd0);
    chk("load_op_count", {16'd0, op_count}, 32'd0);

    // ADD with carry out to zero
    load(2'd0, 16'hFFFF);
    load(2'd1, 16'h0001);
    expect_wb(2'd2, 16'h0000, 1'b1, 1'b1, 16'd1, 1'b0);
    issue(3'b101, 2'd2, 2'd0, 2'd1);
    idle(2);
    rd_chk("add_rf2", 2'd2, 16'h0000);

    // AND keeps carry
    load(2'd0, 16'hF0F0);
    load(2'd1, 16'h0FF0);
    expect_wb(2'd3, 16'h00F0, 1'b1, 1'b0, 16'd2, 1'b0);
    issue(3'b001, 2'd3, 2'd0, 2'd1);
    idle(2);

    // Back-to-back increment through forwarding
    load(2'd0, 16'd5);
    expect_wb(2'd0, 16'd6, 1'b1, 1'b0, 16'd3, 1'b0);
    expect_wb(2'd0, 16'd7, 1'b1, 1'b0, 16'd4, 1'b1);
    expect_wb(2'd0, 16'd8, 1'b1, 1'b0, 16'd5, 1'b1);
    issue(3'b111, 2'd0, 2'd0, 2'd0);
    issue(3'b111, 2'd0, 2'd0, 2'd0);
    issue(3'b111, 2'd0, 2'd0, 2'd0);
    idle(2);
    rd_chk("fwd_rf0", 2'd0, 16'd8);

    // SUB borrow, then a chain exercising both forwarded operands
    expect_wb(2'd1, 16'hFF18, 1'b0, 1'b0, 16'd6, 1'b0);
    expect_wb(2'd2, 16'h0000, 1'b0, 1'b1, 16'd7, 1'b1);
    expect_wb(2'd3, 16'hFFFF, 1'b0, 1'b0, 16'd8, 1'b1);
    expect_wb(2'd0, 16'hFFFF, 1'b0, 1'b0, 16'd9, 1'b1);
    expect_wb(2'd0, 16'hFFFE, 1'b0, 1'b0, 16'd10, 1'b1);
    issue(3'b110, 2'd1, 2'd0, 2'd3);
    issue(3'b010, 2'd2, 2'd1, 2'd1);
    issue(3'b000, 2'd3, 2'd2, 2'd2);
    issue(3'b011, 2'd0, 2'd3, 2'd0);
    issue(3'b100, 2'd0, 2'd0, 2'd0);
    idle(2);
    rd_chk("chain_rf0", 2'd0, 16'hFFFE);
    rd_chk("chain_rf1", 2'd1, 16'hFF18);

    // Load beats a simultaneous instruction; instruction goes next cycle
    instr_valid = 1'b1; instr_op = 3'b111; instr_rd = 2'd1; instr_rs1 = 2'd0; instr_rs2 = 2'd0;
    ld_en = 1'b1; ld_addr = 2'd0; ld_data = 16'h0010;
    #1;
    chk("prio_instr_ready", {31'd0, instr_ready}, 32'd0);
    chk("prio_ld_ready", {31'd0, ld_ready}, 32'd1);
    expect_wb(2'd1, 16'h0011, 1'b0, 1'b0, 16'd11, 1'b0);
    @(posedge clk); #1;
    ld_en = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 2'd2; ld_data = 16'hABCD;
    #1;
    chk("stall_ld_ready", {31'd0, ld_ready}, 32'd0);
    load(2'd2, 16'hABCD);
    rd_chk("prio_rf0", 2'd0, 16'h0010);
    rd_chk("prio_rf1", 2'd1, 16'h0011);
    rd_chk("stall_rf2", 2'd2, 16'hABCD);
    chk("load_keeps_count", {16'd0, op_count}, 32'd11);

    // Asynchronous reset between accept and writeback
    load(2'd3, 16'h0007);
    issue(3'b111, 2'd2, 2'd3, 2'd3);
    instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    rf_raddr = 2'd2;
    #1;
    chk("arst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("arst_wb_data", {16'd0, wb_data}, 32'd0);
    chk("arst_op_count", {16'd0, op_count}, 32'd0);
    chk("arst_alu_a", {16'd0, alu_a}, 32'd0);
    chk("arst_flag_c", {31'd0, flag_c}, 32'd0);
    chk("arst_rf2", {16'd0, rf_rdata}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Retire counter wrap
    load(2'd0, 16'h0000);
    for (int i = 0; i < 65536; i++) begin
      expect_wb(2'd1, 16'h0000, 1'b0, 1'b1, 16'(i + 1), i > 0);
      issue(3'b001, 2'd1, 2'd0, 2'd0);
    end
    idle(2);
    chk("wrap_op_count", {16'd0, op_count}, 32'd0);

    for (int k = 0; k < 10 && sbq.size() != 0; k++) @(posedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
